// File: rtl/rec_pkg.sv
// Shared constants, state encoding and parity helper for the serial frame receiver.
package rec_pkg;
  localparam int FRAME_W = 44;
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY} rec_state_t;

  // Even parity: the running XOR of the data bits combined with the parity bit is 0 for a clean frame.
  function automatic logic par_err(input logic run_par, input logic par_bit);
    return run_par ^ par_bit;
  endfunction
endpackage

// File: rtl/rec_shift.sv
// Receive shift register: MSB-first capture of the serial line with a running XOR of the shifted bits.
module rec_shift import rec_pkg::*; #(
  parameter int W = FRAME_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         shift_en,
  input  logic         din,
  output logic [W-1:0] q,
  output logic         par
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q   <= '0;
      par <= 1'b0;
    end else if (shift_en) begin
      q   <= {q[W-2:0], din};
      par <= par ^ din;
    end
  end

endmodule

// File: rtl/rec_frame_ctrl.sv
// Frame controller: start-bit detect, 44-bit capture, even-parity check and a single-entry valid/ready output register.
module rec_frame_ctrl #(
  parameter int FRAME_W = rec_pkg::FRAME_W,
  parameter int CNT_W   = rec_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               ain,
  output logic [FRAME_W-1:0] frame_data,
  output logic               frame_valid,
  input  logic               frame_ready,
  output logic               frame_err,
  output logic               overrun,
  output logic               busy,
  output logic [CNT_W-1:0]   bit_cnt
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_W - 1);

  rec_pkg::rec_state_t state, nxt;
  logic               clr, shift_en, commit;
  logic [FRAME_W-1:0] sh_q;
  logic               sh_par;

  rec_shift #(.W(FRAME_W)) u_shift (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .shift_en (shift_en),
    .din      (ain),
    .q        (sh_q),
    .par      (sh_par)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= rec_pkg::IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt      = state;
    clr      = 1'b0;
    shift_en = 1'b0;
    commit   = 1'b0;
    case (state)
      rec_pkg::IDLE: begin
        if (en && ain) begin
          clr = 1'b1;
          nxt = rec_pkg::DATA;
        end
      end
      rec_pkg::DATA: begin
        if (!en) nxt = rec_pkg::IDLE;
        else begin
          shift_en = 1'b1;
          if (bit_cnt == LAST) nxt = rec_pkg::PARITY;
        end
      end
      rec_pkg::PARITY: begin
        // An abort here simply discards the frame: no commit, no overrun.
        commit = en;
        nxt    = rec_pkg::IDLE;
      end
      default: nxt = rec_pkg::IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt     <= '0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (clr)                          bit_cnt <= '0;
      else if (shift_en && bit_cnt != LAST) bit_cnt <= bit_cnt + CNT_W'(1);

      // A commit may reuse the slot in the same cycle the pending frame is accepted.
      if (commit && (!frame_valid || frame_ready)) begin
        frame_data  <= sh_q;
        frame_err   <= rec_pkg::par_err(sh_par, ain);
        frame_valid <= 1'b1;
      end else if (commit) begin
        overrun <= 1'b1;
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != rec_pkg::IDLE);

endmodule

// File: tb/tb_rec_frame_ctrl.sv
// Directed bench for rec_frame_ctrl: inputs change and outputs are sampled on the falling edge.
module tb_rec_frame_ctrl;
  logic        clk = 1'b0;
  logic        rst, en, ain, frame_ready;
  logic [43:0] frame_data;
  logic        frame_valid, frame_err, overrun, busy;
  logic [5:0]  bit_cnt;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [43:0] D1 = 44'h0F0_0000_0001; // 5 ones  -> parity 1
  localparam logic [43:0] DA = 44'hAAA_AAAA_AAAA; // 22 ones -> parity 0
  localparam logic [43:0] DB = 44'h123_4567_89AB; // 20 ones -> parity 0

  rec_frame_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .ain         (ain),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .busy        (busy),
    .bit_cnt     (bit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic b);
    ain = b;
    @(negedge clk);
  endtask

  // Start bit, 44 data bits MSB first, parity bit; frame_ready is driven only for the parity edge.
  task automatic send(input logic [43:0] d, input logic p, input logic rdy);
    logic [43:0] v;
    v = d;
    cyc(1'b1);
    for (int i = 43; i >= 0; i--) cyc(v[i]);
    frame_ready = rdy;
    cyc(p);
    ain = 1'b0;
    frame_ready = 1'b0;
  endtask

  task automatic accept();
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
  endtask

  initial begin
    logic [43:0] v;
    rst = 1'b1; en = 1'b0; ain = 1'b0; frame_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", frame_valid, 0);
    chk("rst_data",  frame_data,  0);
    chk("rst_err",   frame_err,   0);
    chk("rst_ovr",   overrun,     0);
    chk("rst_busy",  busy,        0);
    chk("rst_cnt",   bit_cnt,     0);

    // start bit ignored while disabled
    cyc(1'b1);
    ain = 1'b0;
    chk("dis_busy", busy, 0);
    en = 1'b1;

    // single good frame, held until accepted
    send(D1, 1'b1, 1'b0);
    chk("f1_valid", frame_valid, 1);
    chk("f1_data",  frame_data,  D1);
    chk("f1_err",   frame_err,   0);
    chk("f1_busy",  busy,        0);
    chk("f1_cnt",   bit_cnt,     43);
    repeat (3) @(negedge clk);
    chk("f1_hold_valid", frame_valid, 1);
    chk("f1_hold_data",  frame_data,  D1);
    accept();
    chk("f1_acc_valid", frame_valid, 0);

    // parity error
    send(D1, 1'b0, 1'b0);
    chk("pe_valid", frame_valid, 1);
    chk("pe_err",   frame_err,   1);
    chk("pe_data",  frame_data,  D1);
    accept();
    chk("pe_acc_valid", frame_valid, 0);

    // overrun: back-to-back A then B, consumer stalled
    send(DA, 1'b0, 1'b0);
    chk("ov_a_data", frame_data, DA);
    chk("ov_a_ovr",  overrun,    0);
    send(DB, 1'b0, 1'b0);
    chk("ov_pulse", overrun,     1);
    chk("ov_keepA", frame_data,  DA);
    chk("ov_valid", frame_valid, 1);
    @(negedge clk);
    chk("ov_pulse_end", overrun, 0);
    accept();
    chk("ov_acc_valid", frame_valid, 0);

    // collision: accept A on B's parity edge
    send(DA, 1'b0, 1'b0);
    send(DB, 1'b0, 1'b1);
    chk("col_ovr",   overrun,     0);
    chk("col_data",  frame_data,  DB);
    chk("col_valid", frame_valid, 1);
    chk("col_err",   frame_err,   0);
    accept();
    chk("col_acc_valid", frame_valid, 0);

    // abort after 20 data bits
    v = DA;
    cyc(1'b1);
    chk("ab_busy_start", busy,    1);
    chk("ab_cnt_start",  bit_cnt, 0);
    for (int i = 43; i >= 24; i--) cyc(v[i]);
    chk("ab_cnt20", bit_cnt, 20);
    en = 1'b0; ain = 1'b0;
    @(negedge clk);
    chk("ab_busy",  busy,        0);
    chk("ab_valid", frame_valid, 0);
    en = 1'b1;
    send(D1, 1'b1, 1'b0);
    chk("ab_next_valid", frame_valid, 1);
    chk("ab_next_data",  frame_data,  D1);
    chk("ab_next_err",   frame_err,   0);
    accept();

    // reset mid-frame with a frame pending
    send(DA, 1'b0, 1'b0);
    v = DB;
    cyc(1'b1);
    for (int i = 43; i >= 14; i--) cyc(v[i]);
    chk("mr_busy_pre", busy, 1);
    rst = 1'b1; ain = 1'b1;
    @(negedge clk);
    rst = 1'b0; ain = 1'b0;
    chk("mr_valid", frame_valid, 0);
    chk("mr_data",  frame_data,  0);
    chk("mr_busy",  busy,        0);
    chk("mr_cnt",   bit_cnt,     0);
    chk("mr_err",   frame_err,   0);
    chk("mr_ovr",   overrun,     0);
    send(DB, 1'b1, 1'b0);
    chk("mr_next_valid", frame_valid, 1);
    chk("mr_next_data",  frame_data,  DB);
    chk("mr_next_err",   frame_err,   1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
